gemm_tile_drain: RTL
====================

GEMM_TILE_DRAIN -- requirements
Module: gemm_tile_drain

Interface
REQ-001 Parameter N, default 4: systolic tile dimension (N x N accumulators).
REQ-002 Parameter ACC_W, default 32: signed accumulator width per element.
REQ-003 Parameter OUT_W, default 16: signed output element width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 tile_valid  input  1  producer presents a completed accumulator tile.
REQ-007 tile_ready  output  1  block can capture a tile this cycle.
REQ-008 tile_data  input  N*N*ACC_W  flattened row-major tile; element [i][j] at bits (i*N+j)*ACC_W +: ACC_W.
REQ-009 out_valid  output  1  output row valid.
REQ-010 out_ready  input  1  consumer accepts the output row.
REQ-011 out_data  output  N*OUT_W  one tile row; column j at bits j*OUT_W +: OUT_W.
REQ-012 out_row  output  clog2(N)  index of the row on out_data.
REQ-013 out_last  output  1  high with row N-1.
REQ-014 out_sat  output  N  per-column saturation flag for the current row.
REQ-015 busy  output  1  high while a tile is held or being drained.
REQ-016 tiles_done  output  16  count of fully drained tiles, wraps 0xFFFF->0.

Function
REQ-017 States SHALL be IDLE and DRAIN only; the state SHALL be registered.
REQ-018 tile_ready SHALL be 1 in IDLE, and 1 in DRAIN only in the cycle where out_valid && out_ready && out_last; otherwise 0.
REQ-019 Capture SHALL occur on tile_valid && tile_ready: tile_data registered into an internal N x N buffer, row counter set to 0, state to DRAIN.
REQ-020 Latency: tile captured at edge T SHALL give out_valid=1, out_row=0 from the cycle after edge T.
REQ-021 In DRAIN out_valid SHALL be 1; out_data, out_row, out_last, out_sat SHALL hold stable while out_ready=0.
REQ-022 On out_valid && out_ready with row < N-1, the row counter SHALL increment by 1 at that edge.
REQ-023 On out_valid && out_ready with row = N-1: tiles_done SHALL increment; if tile_valid is also 1, the new tile SHALL be captured at the same edge and drained with no bubble; otherwise state SHALL go to IDLE and out_valid SHALL be 0 the next cycle.
REQ-024 tile_valid while tile_ready=0 SHALL be ignored, leaving the buffer unchanged.
REQ-025 busy SHALL equal (state == DRAIN).
REQ-026 Row conversion from ACC_W to OUT_W SHALL follow REQ-031/REQ-032.

Reset
REQ-027 On rst assertion, asynchronously: state IDLE, row counter 0, buffer cleared to 0, tiles_done 0.
REQ-028 During and after reset, outputs SHALL be out_valid 0, out_data 0, out_row 0, out_last 0, out_sat 0, busy 0, tile_ready 1.
REQ-029 Reset during DRAIN SHALL discard the remaining rows; no partial tile SHALL count in tiles_done.

Configuration
REQ-030 Macro GEMM_DRAIN_SAT_EN SHALL select the narrowing mode.
REQ-031 Defined: each element SHALL be saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and the out_sat bit for a clamped column SHALL be 1.
REQ-032 Undefined: each element SHALL be truncated to its low OUT_W bits, and out_sat SHALL be tied to 0.

Verification
REQ-033 Tile with [i][j]=i*4+j, out_ready=1 -> rows 0..3 on four consecutive cycles; row 2 = {11,10,9,8} (col3..col0); out_last on row 3; tiles_done=1.
REQ-034 out_ready held 0 for 5 cycles on row 1 -> out_data and out_row=1 stable for all 5 cycles; tile_ready=0; a tile_valid pulse during the stall is ignored.
REQ-035 Two tiles with tile_valid held high and out_ready=1 -> 8 consecutive valid rows with no gap; tiles_done=2.
REQ-036 Element 40000 and -40000, macro defined -> 32767 and -32768 with out_sat set; macro undefined -> 0x9C40 and 0x63C0 with out_sat=0.
REQ-037 rst asserted mid-drain at row 2 -> out_valid drops immediately, tiles_done unchanged, tile_ready=1; a new tile after release drains from row 0.

Source files
------------

// File: rtl/gemm_tile_drain.sv
// Captures an N x N accumulator tile and streams it out one narrowed row per handshake.
// Narrowing: truncation by default, saturation when GEMM_DRAIN_SAT_EN is defined.
module gemm_tile_drain #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  localparam int RW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tile_valid,
  output logic                   tile_ready,
  input  logic [N*N*ACC_W-1:0]   tile_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*OUT_W-1:0]     out_data,
  output logic [RW-1:0]          out_row,
  output logic                   out_last,
  output logic [N-1:0]           out_sat,
  output logic                   busy,
  output logic [15:0]            tiles_done
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t               state;
  logic [N*N*ACC_W-1:0] tile_q;
  logic [RW-1:0]        row_q;
  logic                 fire;
  logic                 last_fire;
  logic                 capture;
  logic [RW-1:0]        nxt_idx;
  logic [N*ACC_W-1:0]   src_row;
  logic [N*OUT_W-1:0]   nxt_dat;
  logic [N-1:0]         nxt_sat;

  assign fire       = (state == DRAIN) && out_ready;
  assign last_fire  = fire && out_last;
  assign tile_ready = (state == IDLE) || last_fire;
  assign capture    = tile_valid && tile_ready;
  assign busy       = (state == DRAIN);
  assign out_row    = row_q;

  // Output registers are loaded with the row that will be visible next cycle:
  // row 0 of the incoming tile on capture, otherwise the following buffered row.
  assign nxt_idx = (row_q == RW'(N - 1)) ? '0 : row_q + 1'b1;
  assign src_row = capture ? tile_data[N*ACC_W-1:0]
                           : tile_q[nxt_idx*N*ACC_W +: N*ACC_W];

  for (genvar j = 0; j < N; j++) begin : g_col
    logic signed [ACC_W-1:0] acc;
    assign acc = src_row[j*ACC_W +: ACC_W];
`ifdef GEMM_DRAIN_SAT_EN
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
    logic hi, lo;
    assign hi = acc > MAXV;
    assign lo = acc < MINV;
    assign nxt_dat[j*OUT_W +: OUT_W] = hi ? MAXV[OUT_W-1:0] :
                                       lo ? MINV[OUT_W-1:0] : acc[OUT_W-1:0];
    assign nxt_sat[j] = hi | lo;
`else
    assign nxt_dat[j*OUT_W +: OUT_W] = acc[OUT_W-1:0];
    assign nxt_sat[j] = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tile_q     <= '0;
      row_q      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat    <= '0;
      out_last   <= 1'b0;
      tiles_done <= '0;
    end else begin
      if (last_fire)
        tiles_done <= tiles_done + 16'd1;
      if (capture) begin
        tile_q    <= tile_data;
        row_q     <= '0;
        state     <= DRAIN;
        out_valid <= 1'b1;
        out_data  <= nxt_dat;
        out_sat   <= nxt_sat;
        out_last  <= (N == 1);
      end else if (last_fire) begin
        state     <= IDLE;
        row_q     <= '0;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_sat   <= '0;
        out_last  <= 1'b0;
      end else if (fire) begin
        row_q    <= nxt_idx;
        out_data <= nxt_dat;
        out_sat  <= nxt_sat;
        out_last <= (nxt_idx == RW'(N - 1));
      end
    end
  end

endmodule
